// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared constants, bundle layout and occupancy states for decode_stage
package decode_pkg;

  localparam int BUNDLE_W = 57;

  // Bundle layout, LSB first: is_branch, imm, func, op, unit, rd, rs2, rs1
  localparam int BR_BIT   = 0;
  localparam int IMM_LSB  = 1;
  localparam int FUNC_LSB = 33;
  localparam int OP_LSB   = 36;
  localparam int UNIT_LSB = 39;
  localparam int RD_LSB   = 42;
  localparam int RS2_LSB  = 47;
  localparam int RS1_LSB  = 52;

  localparam logic [2:0] UNIT_ASB    = 3'h0;
  localparam logic [2:0] UNIT_LOGIC  = 3'h1;
  localparam logic [2:0] UNIT_BRANCH = 3'h2;
  localparam logic [2:0] UNIT_LSU    = 3'h3;
  localparam logic [2:0] UNIT_MULDIV = 3'h4;
  localparam logic [2:0] UNIT_SYS    = 3'h5;

  localparam logic [2:0] ASB_OP_ADD   = 3'h0;
  localparam logic [2:0] ASB_OP_SUB   = 3'h1;
  localparam logic [2:0] ASB_OP_SLT   = 3'h2;
  localparam logic [2:0] ASB_OP_SLTU  = 3'h3;
  localparam logic [2:0] ASB_OP_LUI   = 3'h4;
  localparam logic [2:0] ASB_OP_AUIPC = 3'h5;

  localparam logic [2:0] LOGIC_OP_AND = 3'h0;
  localparam logic [2:0] LOGIC_OP_OR  = 3'h1;
  localparam logic [2:0] LOGIC_OP_XOR = 3'h2;
  localparam logic [2:0] LOGIC_OP_SLL = 3'h3;
  localparam logic [2:0] LOGIC_OP_SRL = 3'h4;
  localparam logic [2:0] LOGIC_OP_SRA = 3'h5;

  // Conditional branches use funct3 directly; jumps take the two unused funct3 codes
  localparam logic [2:0] BR_OP_JAL  = 3'b010;
  localparam logic [2:0] BR_OP_JALR = 3'b011;

  localparam logic [2:0] SYS_OP_ECALL  = 3'h0;
  localparam logic [2:0] SYS_OP_EBREAK = 3'h1;

  localparam logic [2:0] FN_REG      = 3'h0;
  localparam logic [2:0] FN_IMM      = 3'h1;
  localparam logic [2:0] LSU_FN_LOAD  = 3'h0;
  localparam logic [2:0] LSU_FN_STORE = 3'h1;
  localparam logic [2:0] LSU_FN_FENCE = 3'h2;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_MAIN  = 2'd1,
    OCC_SKID  = 2'd2
  } occ_e;

  // {unit, op} for the shared integer ALU funct3 space; alt selects SUB/SRA
  function automatic logic [5:0] alu_unit_op(input logic [2:0] funct3, input logic alt);
    case (funct3)
      3'b000:  return {UNIT_ASB, alt ? ASB_OP_SUB : ASB_OP_ADD};
      3'b001:  return {UNIT_LOGIC, LOGIC_OP_SLL};
      3'b010:  return {UNIT_ASB, ASB_OP_SLT};
      3'b011:  return {UNIT_ASB, ASB_OP_SLTU};
      3'b100:  return {UNIT_LOGIC, LOGIC_OP_XOR};
      3'b101:  return {UNIT_LOGIC, alt ? LOGIC_OP_SRA : LOGIC_OP_SRL};
      3'b110:  return {UNIT_LOGIC, LOGIC_OP_OR};
      default: return {UNIT_LOGIC, LOGIC_OP_AND};
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - fetch-side and issue-side handshake bundle of decode_stage
interface decode_stage_if
  import decode_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int XLEN  = 32
);
  logic                      i_valid;
  logic                      o_ready;
  logic [32*WIDTH-1:0]       i_inst;
  logic [XLEN-1:0]           i_pc;
  logic                      o_valid;
  logic                      i_ready;
  logic [BUNDLE_W*WIDTH-1:0] o_bundle;
  logic [WIDTH-1:0]          o_slot_valid;
  logic                      o_illegal;
  logic [1:0]                o_illegal_slot;
  logic [XLEN-1:0]           o_pc;

  modport slave (
    input  i_valid, i_inst, i_pc, i_ready,
    output o_ready, o_valid, o_bundle, o_slot_valid, o_illegal, o_illegal_slot, o_pc
  );

  modport master (
    output i_valid, i_inst, i_pc, i_ready,
    input  o_ready, o_valid, o_bundle, o_slot_valid, o_illegal, o_illegal_slot, o_pc
  );
endinterface

// File: rtl/decode_slot.sv
// rtl/decode_slot.sv - combinational RV32I(+M) decode of one instruction into a 57-bit bundle
module decode_slot
  import decode_pkg::*;
#(
  parameter bit EN_M = 1'b0
) (
  input  logic [31:0]         i_inst,
  output logic [BUNDLE_W-1:0] o_bundle,
  output logic                o_legal
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

  assign opcode = i_inst[6:0];
  assign funct3 = i_inst[14:12];
  assign funct7 = i_inst[31:25];
  assign imm_i  = {{20{i_inst[31]}}, i_inst[31:20]};
  assign imm_s  = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
  assign imm_b  = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
  assign imm_u  = {i_inst[31:12], 12'b0};
  assign imm_j  = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
  assign imm_sh = {27'b0, i_inst[24:20]};

  logic [4:0]  f_rs1, f_rs2, f_rd;
  logic [2:0]  f_unit, f_op, f_func;
  logic [31:0] f_imm;
  logic        f_br;

  always_comb begin
    o_legal = 1'b0;
    f_rs1   = '0;
    f_rs2   = '0;
    f_rd    = '0;
    f_unit  = UNIT_ASB;
    f_op    = '0;
    f_func  = '0;
    f_imm   = '0;
    f_br    = 1'b0;
    // Compressed encodings (low bits != 2'b11) fall through as illegal
    if (i_inst[1:0] == 2'b11) begin
      case (opcode)
        OPC_LUI, OPC_AUIPC: begin
          o_legal = 1'b1;
          f_rd    = i_inst[11:7];
          f_op    = (opcode == OPC_LUI) ? ASB_OP_LUI : ASB_OP_AUIPC;
          f_imm   = imm_u;
        end
        OPC_JAL: begin
          o_legal = 1'b1;
          f_rd    = i_inst[11:7];
          f_unit  = UNIT_BRANCH;
          f_op    = BR_OP_JAL;
          f_imm   = imm_j;
          f_br    = 1'b1;
        end
        OPC_JALR: begin
          o_legal = (funct3 == 3'b000);
          f_rd    = i_inst[11:7];
          f_rs1   = i_inst[19:15];
          f_unit  = UNIT_BRANCH;
          f_op    = BR_OP_JALR;
          f_imm   = imm_i;
          f_br    = 1'b1;
        end
        OPC_BRANCH: begin
          o_legal = (funct3[2:1] != 2'b01);
          f_rs1   = i_inst[19:15];
          f_rs2   = i_inst[24:20];
          f_unit  = UNIT_BRANCH;
          f_op    = funct3;
          f_imm   = imm_b;
          f_br    = 1'b1;
        end
        OPC_LOAD: begin
          o_legal = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
          f_rd    = i_inst[11:7];
          f_rs1   = i_inst[19:15];
          f_unit  = UNIT_LSU;
          f_op    = funct3;
          f_func  = LSU_FN_LOAD;
          f_imm   = imm_i;
        end
        OPC_STORE: begin
          o_legal = (funct3[2] == 1'b0) && (funct3[1:0] != 2'b11);
          f_rs1   = i_inst[19:15];
          f_rs2   = i_inst[24:20];
          f_unit  = UNIT_LSU;
          f_op    = funct3;
          f_func  = LSU_FN_STORE;
          f_imm   = imm_s;
        end
        OPC_OP_IMM: begin
          f_rd             = i_inst[11:7];
          f_rs1            = i_inst[19:15];
          f_func           = FN_IMM;
          {f_unit, f_op}   = alu_unit_op(funct3, (funct3 == 3'b101) && i_inst[30]);
          if (funct3 == 3'b001) begin
            o_legal = (funct7 == 7'h00);
            f_imm   = imm_sh;
          end else if (funct3 == 3'b101) begin
            o_legal = (funct7 == 7'h00) || (funct7 == 7'h20);
            f_imm   = imm_sh;
          end else begin
            o_legal = 1'b1;
            f_imm   = imm_i;
          end
        end
        OPC_OP: begin
          f_rd   = i_inst[11:7];
          f_rs1  = i_inst[19:15];
          f_rs2  = i_inst[24:20];
          f_func = FN_REG;
          if (funct7 == 7'h01) begin
            o_legal = EN_M;
            f_unit  = UNIT_MULDIV;
            f_op    = funct3;
          end else begin
            {f_unit, f_op} = alu_unit_op(funct3, i_inst[30]);
            o_legal = (funct7 == 7'h00) ||
                      ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
          end
        end
        OPC_MISC_MEM: begin
          o_legal = (funct3 == 3'b000);
          f_unit  = UNIT_LSU;
          f_func  = LSU_FN_FENCE;
        end
        OPC_SYSTEM: begin
          o_legal = (i_inst == INST_ECALL) || (i_inst == INST_EBREAK);
          f_unit  = UNIT_SYS;
          f_op    = (i_inst == INST_EBREAK) ? SYS_OP_EBREAK : SYS_OP_ECALL;
        end
        default: o_legal = 1'b0;
      endcase
    end
  end

  always_comb begin
    o_bundle                   = '0;
    o_bundle[BR_BIT]           = f_br;
    o_bundle[IMM_LSB  +: 32]   = f_imm;
    o_bundle[FUNC_LSB +: 3]    = f_func;
    o_bundle[OP_LSB   +: 3]    = f_op;
    o_bundle[UNIT_LSB +: 3]    = f_unit;
    o_bundle[RD_LSB   +: 5]    = f_rd;
    o_bundle[RS2_LSB  +: 5]    = f_rs2;
    o_bundle[RS1_LSB  +: 5]    = f_rs1;
  end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered WIDTH-slot decode stage with skid buffer, flush and illegal report
module decode_stage
  import decode_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter bit EN_M  = 1'b0,
  parameter int XLEN  = 32
) (
  input logic          i_clk,
  input logic          i_rst_n,
  input logic          i_flush,
  decode_stage_if.slave bus
);

  localparam int BW     = BUNDLE_W * WIDTH;
  localparam int BEAT_W = XLEN + 2 + 1 + WIDTH + BW;

  logic [BW-1:0]    dec_bundle;
  logic [WIDTH-1:0] dec_legal;

  for (genvar k = 0; k < WIDTH; k++) begin : g_slot
    decode_slot #(.EN_M(EN_M)) u_slot (
      .i_inst   (bus.i_inst[32*k +: 32]),
      .o_bundle (dec_bundle[BUNDLE_W*k +: BUNDLE_W]),
      .o_legal  (dec_legal[k])
    );
  end

  // Slots at or after the first illegal one are never issued
  logic [WIDTH-1:0] slot_ok;
  logic [1:0]       first_bad;
  logic             any_bad;

  always_comb begin
    slot_ok   = '0;
    first_bad = '0;
    any_bad   = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      if (!any_bad && !dec_legal[k]) begin
        any_bad   = 1'b1;
        first_bad = k[1:0];
      end
      slot_ok[k] = dec_legal[k] && !any_bad;
    end
  end

  logic [BEAT_W-1:0] new_beat, main_q, skid_q;
  assign new_beat = {bus.i_pc, first_bad, any_bad, slot_ok, dec_bundle};

  occ_e state_q, state_d;
  logic accept, drain;
  logic load_main_new, load_main_skid, load_skid;

  assign bus.o_valid = (state_q != OCC_EMPTY);
  assign bus.o_ready = (state_q != OCC_SKID);
  assign accept      = bus.i_valid && bus.o_ready;
  assign drain       = bus.o_valid && bus.i_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= OCC_EMPTY;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    load_main_new  = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (i_flush) begin
      state_d = OCC_EMPTY;
    end else begin
      case (state_q)
        OCC_EMPTY: begin
          if (accept) begin
            state_d       = OCC_MAIN;
            load_main_new = 1'b1;
          end
        end
        OCC_MAIN: begin
          if (accept && drain) begin
            load_main_new = 1'b1;
          end else if (accept) begin
            state_d   = OCC_SKID;
            load_skid = 1'b1;
          end else if (drain) begin
            state_d = OCC_EMPTY;
          end
        end
        OCC_SKID: begin
          if (drain) begin
            state_d        = OCC_MAIN;
            load_main_skid = 1'b1;
          end
        end
        default: state_d = OCC_EMPTY;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_new)       main_q <= new_beat;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= new_beat;
    end
  end

  assign bus.o_bundle       = main_q[BW-1:0];
  assign bus.o_slot_valid   = main_q[BW +: WIDTH];
  assign bus.o_illegal      = main_q[BW + WIDTH];
  assign bus.o_illegal_slot = main_q[BW + WIDTH + 1 +: 2];
  assign bus.o_pc           = main_q[BW + WIDTH + 3 +: XLEN];

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed self-checking bench for decode_stage (WIDTH=2, EN_M=0 and EN_M=1)
module tb_decode_stage;

  logic clk;
  logic rst_n;
  logic flush;
  int   checks;
  int   failures;

  decode_stage_if #(.WIDTH(2), .XLEN(32)) bus0 ();
  decode_stage_if #(.WIDTH(2), .XLEN(32)) bus1 ();

  decode_stage #(.WIDTH(2), .EN_M(1'b0), .XLEN(32)) dut0 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_flush (flush),
    .bus     (bus0.slave)
  );

  decode_stage #(.WIDTH(2), .EN_M(1'b1), .XLEN(32)) dut1 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_flush (flush),
    .bus     (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer0(input logic [63:0] inst, input logic [31:0] pc);
    bus0.i_inst  = inst;
    bus0.i_pc    = pc;
    bus0.i_valid = 1'b1;
  endtask

  task automatic test_reset();
    checks++; if (bus0.o_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0h exp=0", bus0.o_valid); end
    checks++; if (bus0.o_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%0h exp=1", bus0.o_ready); end
    checks++; if (bus0.o_bundle !== 114'd0) begin failures++; $display("FAIL rst_bundle got=%0h exp=0", bus0.o_bundle); end
    checks++; if (bus0.o_slot_valid !== 2'b00) begin failures++; $display("FAIL rst_slot_valid got=%0b exp=00", bus0.o_slot_valid); end
    checks++; if (bus0.o_illegal !== 1'b0) begin failures++; $display("FAIL rst_illegal got=%0h exp=0", bus0.o_illegal); end
    checks++; if (bus0.o_illegal_slot !== 2'd0) begin failures++; $display("FAIL rst_illegal_slot got=%0h exp=0", bus0.o_illegal_slot); end
    checks++; if (bus0.o_pc !== 32'd0) begin failures++; $display("FAIL rst_pc got=%0h exp=0", bus0.o_pc); end
  endtask

  task automatic test_basic();
    logic [56:0] s0, s1;
    offer0({32'h002081B3, 32'h00500093}, 32'h100);
    step();
    bus0.i_valid = 1'b0;
    s0 = bus0.o_bundle[56:0];
    s1 = bus0.o_bundle[113:57];
    checks++; if (bus0.o_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%0h exp=1", bus0.o_valid); end
    checks++; if (bus0.o_slot_valid !== 2'b11) begin failures++; $display("FAIL basic_slot_valid got=%0b exp=11", bus0.o_slot_valid); end
    checks++; if (bus0.o_illegal !== 1'b0) begin failures++; $display("FAIL basic_illegal got=%0h exp=0", bus0.o_illegal); end
    checks++; if (bus0.o_pc !== 32'h100) begin failures++; $display("FAIL basic_pc got=%0h exp=100", bus0.o_pc); end
    checks++; if (s0[32:1] !== 32'h5) begin failures++; $display("FAIL basic_s0_imm got=%0h exp=5", s0[32:1]); end
    checks++; if (s0[46:42] !== 5'd1) begin failures++; $display("FAIL basic_s0_rd got=%0d exp=1", s0[46:42]); end
    checks++; if (s0[56:52] !== 5'd0) begin failures++; $display("FAIL basic_s0_rs1 got=%0d exp=0", s0[56:52]); end
    checks++; if (s0[35:33] !== 3'd1) begin failures++; $display("FAIL basic_s0_func got=%0d exp=1", s0[35:33]); end
    checks++; if (s1[46:42] !== 5'd3) begin failures++; $display("FAIL basic_s1_rd got=%0d exp=3", s1[46:42]); end
    checks++; if (s1[56:52] !== 5'd1) begin failures++; $display("FAIL basic_s1_rs1 got=%0d exp=1", s1[56:52]); end
    checks++; if (s1[51:47] !== 5'd2) begin failures++; $display("FAIL basic_s1_rs2 got=%0d exp=2", s1[51:47]); end
    checks++; if (s1[32:1] !== 32'h0) begin failures++; $display("FAIL basic_s1_imm got=%0h exp=0", s1[32:1]); end
    step();
    checks++; if (bus0.o_valid !== 1'b0) begin failures++; $display("FAIL basic_drain got=%0h exp=0", bus0.o_valid); end
  endtask

  task automatic test_illegal_back_to_back();
    logic [56:0] s0;
    offer0({32'hFFFFFFFF, 32'h00000463}, 32'h140);
    step();
    offer0({32'h00500093, 32'hFFFFFFFF}, 32'h148);
    s0 = bus0.o_bundle[56:0];
    checks++; if (bus0.o_slot_valid !== 2'b01) begin failures++; $display("FAIL ill_a_slot_valid got=%0b exp=01", bus0.o_slot_valid); end
    checks++; if (bus0.o_illegal !== 1'b1) begin failures++; $display("FAIL ill_a_illegal got=%0h exp=1", bus0.o_illegal); end
    checks++; if (bus0.o_illegal_slot !== 2'd1) begin failures++; $display("FAIL ill_a_slot got=%0d exp=1", bus0.o_illegal_slot); end
    checks++; if (s0[0] !== 1'b1) begin failures++; $display("FAIL ill_a_is_branch got=%0h exp=1", s0[0]); end
    checks++; if (s0[41:39] !== 3'd2) begin failures++; $display("FAIL ill_a_unit got=%0d exp=2", s0[41:39]); end
    checks++; if (s0[32:1] !== 32'h8) begin failures++; $display("FAIL ill_a_imm got=%0h exp=8", s0[32:1]); end
    checks++; if (bus0.o_pc !== 32'h140) begin failures++; $display("FAIL ill_a_pc got=%0h exp=140", bus0.o_pc); end
    step();
    bus0.i_valid = 1'b0;
    checks++; if (bus0.o_slot_valid !== 2'b00) begin failures++; $display("FAIL ill_b_slot_valid got=%0b exp=00", bus0.o_slot_valid); end
    checks++; if (bus0.o_illegal !== 1'b1) begin failures++; $display("FAIL ill_b_illegal got=%0h exp=1", bus0.o_illegal); end
    checks++; if (bus0.o_illegal_slot !== 2'd0) begin failures++; $display("FAIL ill_b_slot got=%0d exp=0", bus0.o_illegal_slot); end
    checks++; if (bus0.o_pc !== 32'h148) begin failures++; $display("FAIL ill_b_pc got=%0h exp=148", bus0.o_pc); end
    step();
    checks++; if (bus0.o_valid !== 1'b0) begin failures++; $display("FAIL ill_drain got=%0h exp=0", bus0.o_valid); end
  endtask

  task automatic test_formats();
    logic [56:0] s0, s1;
    offer0({32'hFE112E23, 32'h123452B7}, 32'h180);
    step();
    offer0({32'h00000073, 32'h008000EF}, 32'h188);
    s0 = bus0.o_bundle[56:0];
    s1 = bus0.o_bundle[113:57];
    checks++; if (s0[32:1] !== 32'h12345000) begin failures++; $display("FAIL lui_imm got=%0h exp=12345000", s0[32:1]); end
    checks++; if (s0[46:42] !== 5'd5) begin failures++; $display("FAIL lui_rd got=%0d exp=5", s0[46:42]); end
    checks++; if (s1[32:1] !== 32'hFFFFFFFC) begin failures++; $display("FAIL sw_imm got=%0h exp=fffffffc", s1[32:1]); end
    checks++; if (s1[56:52] !== 5'd2) begin failures++; $display("FAIL sw_rs1 got=%0d exp=2", s1[56:52]); end
    checks++; if (s1[51:47] !== 5'd1) begin failures++; $display("FAIL sw_rs2 got=%0d exp=1", s1[51:47]); end
    checks++; if (s1[41:39] !== 3'd3) begin failures++; $display("FAIL sw_unit got=%0d exp=3", s1[41:39]); end
    step();
    bus0.i_valid = 1'b0;
    s0 = bus0.o_bundle[56:0];
    s1 = bus0.o_bundle[113:57];
    checks++; if (bus0.o_slot_valid !== 2'b11) begin failures++; $display("FAIL jal_slot_valid got=%0b exp=11", bus0.o_slot_valid); end
    checks++; if (s0[0] !== 1'b1) begin failures++; $display("FAIL jal_is_branch got=%0h exp=1", s0[0]); end
    checks++; if (s0[32:1] !== 32'h8) begin failures++; $display("FAIL jal_imm got=%0h exp=8", s0[32:1]); end
    checks++; if (s0[46:42] !== 5'd1) begin failures++; $display("FAIL jal_rd got=%0d exp=1", s0[46:42]); end
    checks++; if (s1[41:39] !== 3'd5) begin failures++; $display("FAIL ecall_unit got=%0d exp=5", s1[41:39]); end
    checks++; if (s1[0] !== 1'b0) begin failures++; $display("FAIL ecall_is_branch got=%0h exp=0", s1[0]); end
    step();
  endtask

  task automatic test_backpressure();
    bus0.i_ready = 1'b0;
    offer0({32'h00500093, 32'h00500093}, 32'h200);
    step();
    checks++; if (bus0.o_valid !== 1'b1) begin failures++; $display("FAIL bp_valid1 got=%0h exp=1", bus0.o_valid); end
    checks++; if (bus0.o_ready !== 1'b1) begin failures++; $display("FAIL bp_ready1 got=%0h exp=1", bus0.o_ready); end
    offer0({32'h00500093, 32'h00500093}, 32'h300);
    step();
    checks++; if (bus0.o_ready !== 1'b0) begin failures++; $display("FAIL bp_ready2 got=%0h exp=0", bus0.o_ready); end
    checks++; if (bus0.o_pc !== 32'h200) begin failures++; $display("FAIL bp_pc2 got=%0h exp=200", bus0.o_pc); end
    offer0({32'h00500093, 32'h00500093}, 32'h400);
    step();
    checks++; if (bus0.o_valid !== 1'b1) begin failures++; $display("FAIL bp_valid3 got=%0h exp=1", bus0.o_valid); end
    checks++; if (bus0.o_pc !== 32'h200) begin failures++; $display("FAIL bp_pc3 got=%0h exp=200", bus0.o_pc); end
    checks++; if (bus0.o_ready !== 1'b0) begin failures++; $display("FAIL bp_ready3 got=%0h exp=0", bus0.o_ready); end
    bus0.i_ready = 1'b1;
    step();
    bus0.i_valid = 1'b0;
    checks++; if (bus0.o_valid !== 1'b1) begin failures++; $display("FAIL bp_valid4 got=%0h exp=1", bus0.o_valid); end
    checks++; if (bus0.o_pc !== 32'h300) begin failures++; $display("FAIL bp_pc4 got=%0h exp=300", bus0.o_pc); end
    checks++; if (bus0.o_ready !== 1'b1) begin failures++; $display("FAIL bp_ready4 got=%0h exp=1", bus0.o_ready); end
    step();
    checks++; if (bus0.o_valid !== 1'b0) begin failures++; $display("FAIL bp_no_dup got=%0h exp=0", bus0.o_valid); end
  endtask

  task automatic test_flush();
    bus0.i_ready = 1'b0;
    offer0({32'h00500093, 32'h00500093}, 32'h500);
    step();
    offer0({32'h00500093, 32'h00500093}, 32'h600);
    step();
    checks++; if (bus0.o_ready !== 1'b0) begin failures++; $display("FAIL fl_skid_ready got=%0h exp=0", bus0.o_ready); end
    flush = 1'b1;
    offer0({32'h00500093, 32'h00500093}, 32'h700);
    step();
    flush        = 1'b0;
    bus0.i_valid = 1'b0;
    bus0.i_ready = 1'b1;
    checks++; if (bus0.o_valid !== 1'b0) begin failures++; $display("FAIL fl_valid got=%0h exp=0", bus0.o_valid); end
    checks++; if (bus0.o_ready !== 1'b1) begin failures++; $display("FAIL fl_ready got=%0h exp=1", bus0.o_ready); end
    step();
    checks++; if (bus0.o_valid !== 1'b0) begin failures++; $display("FAIL fl_dropped got=%0h exp=0", bus0.o_valid); end
  endtask

  task automatic test_muldiv();
    logic [56:0] s0;
    offer0({32'h00500093, 32'h022081B3}, 32'h800);
    bus1.i_inst  = {32'h00500093, 32'h022081B3};
    bus1.i_pc    = 32'h800;
    bus1.i_valid = 1'b1;
    step();
    bus0.i_valid = 1'b0;
    bus1.i_valid = 1'b0;
    s0 = bus1.o_bundle[56:0];
    checks++; if (bus0.o_slot_valid !== 2'b00) begin failures++; $display("FAIL mul_nom_slot_valid got=%0b exp=00", bus0.o_slot_valid); end
    checks++; if (bus0.o_illegal !== 1'b1) begin failures++; $display("FAIL mul_nom_illegal got=%0h exp=1", bus0.o_illegal); end
    checks++; if (bus0.o_illegal_slot !== 2'd0) begin failures++; $display("FAIL mul_nom_slot got=%0d exp=0", bus0.o_illegal_slot); end
    checks++; if (bus1.o_slot_valid !== 2'b11) begin failures++; $display("FAIL mul_m_slot_valid got=%0b exp=11", bus1.o_slot_valid); end
    checks++; if (bus1.o_illegal !== 1'b0) begin failures++; $display("FAIL mul_m_illegal got=%0h exp=0", bus1.o_illegal); end
    checks++; if (s0[41:39] !== 3'd4) begin failures++; $display("FAIL mul_m_unit got=%0d exp=4", s0[41:39]); end
    checks++; if (s0[38:36] !== 3'd0) begin failures++; $display("FAIL mul_m_op got=%0d exp=0", s0[38:36]); end
    checks++; if (s0[32:1] !== 32'h0) begin failures++; $display("FAIL mul_m_imm got=%0h exp=0", s0[32:1]); end
    step();
  endtask

  task automatic test_async_reset();
    offer0({32'h00500093, 32'h00500093}, 32'h900);
    step();
    bus0.i_valid = 1'b0;
    bus0.i_ready = 1'b0;
    checks++; if (bus0.o_valid !== 1'b1) begin failures++; $display("FAIL ar_loaded got=%0h exp=1", bus0.o_valid); end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (bus0.o_valid !== 1'b0) begin failures++; $display("FAIL ar_valid got=%0h exp=0", bus0.o_valid); end
    checks++; if (bus0.o_ready !== 1'b1) begin failures++; $display("FAIL ar_ready got=%0h exp=1", bus0.o_ready); end
    checks++; if (bus0.o_pc !== 32'h0) begin failures++; $display("FAIL ar_pc got=%0h exp=0", bus0.o_pc); end
    @(negedge clk);
    rst_n        = 1'b1;
    bus0.i_ready = 1'b1;
    step();
    checks++; if (bus0.o_valid !== 1'b0) begin failures++; $display("FAIL ar_after got=%0h exp=0", bus0.o_valid); end
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst_n        = 1'b0;
    flush        = 1'b0;
    bus0.i_valid = 1'b0;
    bus0.i_ready = 1'b1;
    bus0.i_inst  = '0;
    bus0.i_pc    = '0;
    bus1.i_valid = 1'b0;
    bus1.i_ready = 1'b1;
    bus1.i_inst  = '0;
    bus1.i_pc    = '0;
    repeat (3) step();
    test_reset();
    rst_n = 1'b1;
    step();
    test_reset();
    test_basic();
    test_illegal_back_to_back();
    test_formats();
    test_backpressure();
    test_flush();
    test_muldiv();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
